cpu_control_fsm: RTL and testbench

- Multi-cycle control unit directly upstream of the 16-bit datapath.
- Takes the instruction register contents, the ALU zero flag and a memory ready handshake.
- Drives every datapath enable and select for a fixed 16-bit ISA, one instruction at a time.
- Counts retired instructions and flags illegal opcodes and memory timeouts.

---
 rtl/cpu_control_fsm.sv | 171 +++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the 16-bit datapath: sequences fetch, decode,
// execute, memory and writeback, and counts retired instructions.
module cpu_control_fsm #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             ir_en,
  output logic             addr_sel,
  output logic             mem_re,
  output logic             mem_we,
  output logic [1:0]       alu_op,
  output logic             alu_src_b,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             halted,
  output logic             fault,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT, S_FAULT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LD   = 4'd5;
  localparam logic [3:0] OP_ST   = 4'd6;
  localparam logic [3:0] OP_BEQZ = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  // Last wait-count value before a still-pending access becomes a fault.
  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t           state_reg;
  logic [15:0]      wait_cnt_reg;
  logic [CNT_W-1:0] retired_reg;
  logic             illegal_reg;
  logic [3:0]       opcode;
  logic             unused_instr_bits;

  assign opcode            = instr[15:12];
  assign unused_instr_bits = ^instr[11:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 16'd0;
      retired_reg  <= '0;
      illegal_reg  <= 1'b0;
    end else begin
      illegal_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) state_reg <= S_FETCH;
        end
        S_FETCH, S_MEM: begin
          if (mem_ready) begin
            wait_cnt_reg <= 16'd0;
            if (state_reg == S_FETCH) begin
              state_reg <= S_DECODE;
            end else if (opcode == OP_LD) begin
              state_reg <= S_WRITEBACK;
            end else begin
              retired_reg <= retired_reg + CNT_W'(1);
              state_reg   <= S_FETCH;
            end
          end else if (wait_cnt_reg == WAIT_LAST) begin
            wait_cnt_reg <= 16'd0;
            state_reg    <= S_FAULT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
        end
        S_DECODE: begin
          if (opcode <= OP_JMP) begin
            state_reg <= S_EXECUTE;
          end else if (opcode == OP_HALT) begin
            retired_reg <= retired_reg + CNT_W'(1);
            state_reg   <= S_HALT;
          end else begin
            illegal_reg <= 1'b1;
            state_reg   <= S_FETCH;
          end
        end
        S_EXECUTE: begin
          case (opcode)
            OP_LD, OP_ST: state_reg <= S_MEM;
            OP_BEQZ, OP_JMP: begin
              retired_reg <= retired_reg + CNT_W'(1);
              state_reg   <= S_FETCH;
            end
            default: state_reg <= S_WRITEBACK;
          endcase
        end
        S_WRITEBACK: begin
          retired_reg <= retired_reg + CNT_W'(1);
          state_reg   <= S_FETCH;
        end
        default: state_reg <= state_reg;
      endcase
    end
  end

  always_comb begin
    pc_en     = 1'b0;
    pc_sel    = 2'b00;
    ir_en     = 1'b0;
    addr_sel  = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    alu_op    = 2'b00;
    alu_src_b = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_re = 1'b1;
        if (mem_ready) begin
          ir_en = 1'b1;
          pc_en = 1'b1;
        end
      end
      S_EXECUTE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: alu_op = opcode[1:0];
          OP_ADDI, OP_LD, OP_ST:         alu_src_b = 1'b1;
          OP_BEQZ: begin
            if (zero) begin
              pc_en  = 1'b1;
              pc_sel = 2'b01;
            end
          end
          OP_JMP: begin
            pc_en  = 1'b1;
            pc_sel = 2'b10;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        addr_sel = 1'b1;
        if (opcode == OP_LD) mem_re = 1'b1;
        else                 mem_we = 1'b1;
      end
      S_WRITEBACK: begin
        reg_we = 1'b1;
        wb_sel = (opcode == OP_LD);
      end
      default: ;
    endcase
  end

  assign halted  = (state_reg == S_HALT);
  assign fault   = (state_reg == S_FAULT);
  assign illegal = illegal_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomized bench for cpu_control_fsm: expected per-cycle control vectors are
// built from each instruction's cycle recipe and the retire count is modelled.
module tb_cpu_control_fsm;
  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk, rst_n, start, zero, mem_ready;
  logic [15:0]   instr;
  logic          pc_en, ir_en, addr_sel, mem_re, mem_we, alu_src_b, reg_we, wb_sel;
  logic          halted, fault, illegal;
  logic [1:0]    pc_sel, alu_op;
  logic [CW-1:0] retired;

  cpu_control_fsm #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .pc_sel(pc_sel), .ir_en(ir_en),
    .addr_sel(addr_sel), .mem_re(mem_re), .mem_we(mem_we), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .reg_we(reg_we), .wb_sel(wb_sel), .halted(halted),
    .fault(fault), .illegal(illegal), .retired(retired)
  );

  // Observed control vector: {pc_en, pc_sel, ir_en, addr_sel, mem_re, mem_we,
  // alu_op, alu_src_b, reg_we, wb_sel, halted, fault, illegal}
  logic [14:0] obs_vec;
  assign obs_vec = {pc_en, pc_sel, ir_en, addr_sel, mem_re, mem_we, alu_op,
                    alu_src_b, reg_we, wb_sel, halted, fault, illegal};

  localparam logic [14:0] E_PC_EN  = 15'h4000;
  localparam logic [14:0] E_SEL_BR = 15'h1000;
  localparam logic [14:0] E_SEL_J  = 15'h2000;
  localparam logic [14:0] E_IR     = 15'h0800;
  localparam logic [14:0] E_ADDR   = 15'h0400;
  localparam logic [14:0] E_RE     = 15'h0200;
  localparam logic [14:0] E_WE     = 15'h0100;
  localparam logic [14:0] E_SRCB   = 15'h0020;
  localparam logic [14:0] E_REGWE  = 15'h0010;
  localparam logic [14:0] E_WBMEM  = 15'h0008;
  localparam logic [14:0] E_HALT   = 15'h0004;
  localparam logic [14:0] E_FAULT  = 15'h0002;
  localparam logic [14:0] E_ILL    = 15'h0001;

  int checks = 0;
  int failures = 0;
  int ret_model = 0;
  bit ill_pend = 0;
  bit dead = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive mem_ready, compare at the falling edge, advance.
  task automatic step(input logic [14:0] exp, input logic mr, input string tag, input bit ret);
    mem_ready = mr;
    @(negedge clk);
    check({tag, " ctl"}, 32'(obs_vec), 32'(exp));
    check({tag, " retired"}, 32'(retired), 32'(ret_model));
    @(posedge clk); #1;
    if (ret) ret_model = (ret_model + 1) % (1 << CW);
  endtask

  task automatic tail(input logic [14:0] exp, input string tag);
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom);
      step(exp, 1'($urandom), tag, 0);
    end
    dead = 1;
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #2;
    check("async-reset ctl", 32'(obs_vec), 32'd0);
    check("async-reset retired", 32'(retired), 32'd0);
    ret_model = 0;
    ill_pend  = 0;
    dead      = 0;
    start     = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(15'd0, 1'($urandom), "idle", 0);
    start = 1'b1;
    step(15'd0, 1'($urandom), "idle-start", 0);
    start = 1'($urandom);
  endtask

  task automatic run_instr(input logic [3:0] op, input logic z, input int fd, input int md);
    logic [14:0] il, mv;
    string t;
    instr = {op, 12'($urandom)};
    zero  = z;
    t     = $sformatf("op%0h", op);
    il    = ill_pend ? E_ILL : 15'd0;
    ill_pend = 0;
    for (int i = 0; i < fd && i < TO; i++) begin
      step(E_RE | il, 1'b0, {t, " fetch-wait"}, 0);
      il = 15'd0;
    end
    if (fd >= TO) begin
      tail(E_FAULT, {t, " fetch-fault"});
      return;
    end
    step(E_RE | E_IR | E_PC_EN | il, 1'b1, {t, " fetch"}, 0);
    step(15'd0, 1'($urandom), {t, " decode"}, op == 4'd15);
    if (op == 4'd15) begin
      tail(E_HALT, {t, " halt"});
      return;
    end
    if (op >= 4'd9) begin
      ill_pend = 1;
      return;
    end
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        step(15'(op[1:0]) << 6, 1'($urandom), {t, " exec"}, 0);
        step(E_REGWE, 1'($urandom), {t, " wb"}, 1);
      end
      4'd4: begin
        step(E_SRCB, 1'($urandom), {t, " exec"}, 0);
        step(E_REGWE, 1'($urandom), {t, " wb"}, 1);
      end
      4'd5, 4'd6: begin
        step(E_SRCB, 1'($urandom), {t, " exec"}, 0);
        mv = E_ADDR | ((op == 4'd5) ? E_RE : E_WE);
        for (int i = 0; i < md && i < TO; i++) step(mv, 1'b0, {t, " mem-wait"}, 0);
        if (md >= TO) begin
          tail(E_FAULT, {t, " mem-fault"});
          return;
        end
        step(mv, 1'b1, {t, " mem"}, op == 4'd6);
        if (op == 4'd5) step(E_REGWE | E_WBMEM, 1'($urandom), {t, " wb"}, 1);
      end
      4'd7: step(z ? (E_PC_EN | E_SEL_BR) : 15'd0, 1'($urandom), {t, " exec"}, 1);
      default: step(E_PC_EN | E_SEL_J, 1'($urandom), {t, " exec"}, 1);
    endcase
  endtask

  initial begin
    logic [3:0] op;
    rst_n = 1'b0; start = 1'b0; zero = 1'b0; mem_ready = 1'b0; instr = 16'h0;
    @(posedge clk); #1;
    do_reset();
    // Abandon an instruction mid-FETCH via asynchronous reset.
    instr = 16'h0298;
    step(E_RE, 1'b0, "pre-reset fetch", 0);
    step(E_RE, 1'b0, "pre-reset fetch", 0);
    do_reset();

    run_instr(4'h0, 1'b0, 0, 0);
    run_instr(4'h5, 1'b0, 0, 3);
    run_instr(4'h7, 1'b1, 0, 0);
    run_instr(4'h7, 1'b0, 1, 0);
    run_instr(4'hA, 1'b0, 0, 0);
    run_instr(4'h1, 1'b0, 2, 0);
    run_instr(4'h6, 1'b0, 0, TO - 1);
    run_instr(4'h0, 1'b0, TO - 1, 0);
    for (int i = 0; i < 17; i++) run_instr(4'h8, 1'b0, 0, 0);
    run_instr(4'h2, 1'b0, TO, 0);
    do_reset();
    run_instr(4'h6, 1'b0, 0, TO);
    do_reset();
    run_instr(4'h3, 1'b0, 0, 0);
    run_instr(4'hF, 1'b0, 0, 0);
    do_reset();

    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 99) < 3) ? 4'hF : 4'($urandom_range(0, 14));
      run_instr(op, 1'($urandom),
                ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, TO - 1)),
                ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, TO - 1)));
      if (dead) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
